// File: rtl/fft16_pkg.sv
// Shared constants, twiddle table, FSM state type and index helpers for the
// 16-point iterative radix-2 DIT FFT engine.
package fft16_pkg;

  localparam int IN_W    = 16;  // Q8.8 input samples and saturated outputs
  localparam int ACC_W   = 24;  // working register component width
  localparam int TW_W    = 16;  // Q1.14 twiddle component width
  localparam int Q_SHIFT = 14;  // twiddle fraction bits
  localparam int N       = 16;

  typedef enum logic [1:0] {IDLE, LOAD, STAGE, OUT} fft_state_t;

  // W^m = e^(-j*2*pi*m/16) as {re, im}, each round(16384 * value).
  function automatic logic [2*TW_W-1:0] tw_val(input logic [2:0] m);
    case (m)
      3'd0:    tw_val = {16'sd16384,  16'sd0};
      3'd1:    tw_val = {16'sd15137, -16'sd6270};
      3'd2:    tw_val = {16'sd11585, -16'sd11585};
      3'd3:    tw_val = {16'sd6270,  -16'sd15137};
      3'd4:    tw_val = {16'sd0,     -16'sd16384};
      3'd5:    tw_val = {-16'sd6270, -16'sd15137};
      3'd6:    tw_val = {-16'sd11585, -16'sd11585};
      default: tw_val = {-16'sd15137, -16'sd6270};
    endcase
  endfunction

  function automatic logic [3:0] bitrev4(input logic [3:0] i);
    bitrev4 = {i[0], i[1], i[2], i[3]};
  endfunction

  // Upper-leg index of butterfly b (0..7) in stage s; the lower leg is
  // top + 2^s. Stage s pairs entries 2^s apart inside groups of 2^(s+1).
  function automatic logic [3:0] top_idx(input logic [1:0] s, input logic [2:0] b);
    case (s)
      2'd0:    top_idx = {b, 1'b0};
      2'd1:    top_idx = {b[2:1], 1'b0, b[0]};
      2'd2:    top_idx = {b[2], 1'b0, b[1:0]};
      default: top_idx = {1'b0, b};
    endcase
  endfunction

  // Twiddle exponent: position inside the group times 8 / 2^s.
  function automatic logic [2:0] tw_idx(input logic [1:0] s, input logic [2:0] b);
    case (s)
      2'd0:    tw_idx = 3'd0;
      2'd1:    tw_idx = {b[0], 2'b00};
      2'd2:    tw_idx = {b[1:0], 1'b0};
      default: tw_idx = b;
    endcase
  endfunction

  function automatic logic [IN_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > 32767)        sat16 = 16'h7FFF;
    else if (v < -32768)  sat16 = 16'h8000;
    else                  sat16 = 16'(v);
  endfunction

endpackage

// File: rtl/fft_bfly.sv
// Combinational radix-2 DIT butterfly: x = a + b*w, y = a - b*w.
// The complex product keeps full precision, then truncates by Q_SHIFT;
// the add/sub wraps at ACC_W bits.
module fft_bfly
  import fft16_pkg::*;
(
  input  logic signed [ACC_W-1:0] a_re,
  input  logic signed [ACC_W-1:0] a_im,
  input  logic signed [ACC_W-1:0] b_re,
  input  logic signed [ACC_W-1:0] b_im,
  input  logic signed [TW_W-1:0]  w_re,
  input  logic signed [TW_W-1:0]  w_im,
  output logic signed [ACC_W-1:0] x_re,
  output logic signed [ACC_W-1:0] x_im,
  output logic signed [ACC_W-1:0] y_re,
  output logic signed [ACC_W-1:0] y_im
);

  logic signed [ACC_W+TW_W-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [ACC_W+TW_W:0]   s_re, s_im;
  logic signed [ACC_W-1:0]      t_re, t_im;

  assign p_rr = b_re * w_re;
  assign p_ii = b_im * w_im;
  assign p_ri = b_re * w_im;
  assign p_ir = b_im * w_re;

  assign s_re = p_rr - p_ii;
  assign s_im = p_ri + p_ir;

  assign t_re = ACC_W'(s_re >>> Q_SHIFT);
  assign t_im = ACC_W'(s_im >>> Q_SHIFT);

  assign x_re = a_re + t_re;
  assign x_im = a_im + t_im;
  assign y_re = a_re - t_re;
  assign y_im = a_im - t_im;

endmodule

// File: rtl/fft16_iter.sv
// 16-point iterative FFT. Samples stream into a ping-pong buffer pair; a
// completed frame is copied bit-reversed into 16 complex working registers
// and transformed in place by two butterflies per cycle over 16 cycles.
//
// Handshake: fir_valid=1 on a rising edge means fir_d is taken on that edge;
// there is no ready, the source is never stalled. fft_valid is a one-cycle
// pulse; fft_d0..15 hold until the next pulse.
module fft16_iter
  import fft16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  fir_d,
  input  logic             fir_valid,
  output logic [31:0]      fft_d0,
  output logic [31:0]      fft_d1,
  output logic [31:0]      fft_d2,
  output logic [31:0]      fft_d3,
  output logic [31:0]      fft_d4,
  output logic [31:0]      fft_d5,
  output logic [31:0]      fft_d6,
  output logic [31:0]      fft_d7,
  output logic [31:0]      fft_d8,
  output logic [31:0]      fft_d9,
  output logic [31:0]      fft_d10,
  output logic [31:0]      fft_d11,
  output logic [31:0]      fft_d12,
  output logic [31:0]      fft_d13,
  output logic [31:0]      fft_d14,
  output logic [31:0]      fft_d15,
  output logic             fft_valid,
  output logic             overrun,
  output fft_state_t       dbg_state
);

  fft_state_t state;
  logic [3:0] cnt;       // stage[3:2], cycle-in-stage[1:0]
  logic [3:0] scnt;      // sample index in the frame being collected
  logic       sel;       // buffer being filled; ~sel holds the pending frame
  logic       pending;
  logic       frame_done;

  logic [IN_W-1:0]         smp_mem [2][N];
  logic signed [ACC_W-1:0] w_re  [N];
  logic signed [ACC_W-1:0] w_im  [N];
  logic signed [ACC_W-1:0] w_nre [N];
  logic signed [ACC_W-1:0] w_nim [N];
  logic [31:0]             fft_q [N];

  logic [1:0] st;
  logic [2:0] b0, b1;
  logic [3:0] t0, u0, t1, u1;
  logic [2*TW_W-1:0] tw0, tw1;
  logic signed [ACC_W-1:0] x0_re, x0_im, y0_re, y0_im;
  logic signed [ACC_W-1:0] x1_re, x1_im, y1_re, y1_im;

  assign frame_done = fir_valid && (scnt == 4'd15);
  assign dbg_state  = state;

  assign st  = cnt[3:2];
  assign b0  = {cnt[1:0], 1'b0};
  assign b1  = {cnt[1:0], 1'b1};
  assign t0  = top_idx(st, b0);
  assign t1  = top_idx(st, b1);
  assign u0  = t0 | (4'd1 << st);
  assign u1  = t1 | (4'd1 << st);
  assign tw0 = tw_val(tw_idx(st, b0));
  assign tw1 = tw_val(tw_idx(st, b1));

  fft_bfly u_bfly0 (
    .a_re(w_re[t0]), .a_im(w_im[t0]), .b_re(w_re[u0]), .b_im(w_im[u0]),
    .w_re(tw0[31:16]), .w_im(tw0[15:0]),
    .x_re(x0_re), .x_im(x0_im), .y_re(y0_re), .y_im(y0_im)
  );

  fft_bfly u_bfly1 (
    .a_re(w_re[t1]), .a_im(w_im[t1]), .b_re(w_re[u1]), .b_im(w_im[u1]),
    .w_re(tw1[31:16]), .w_im(tw1[15:0]),
    .x_re(x1_re), .x_im(x1_im), .y_re(y1_re), .y_im(y1_im)
  );

  // Working registers after this cycle's two butterflies (disjoint legs).
  always_comb begin
    w_nre = w_re;
    w_nim = w_im;
    w_nre[t0] = x0_re;  w_nim[t0] = x0_im;
    w_nre[u0] = y0_re;  w_nim[u0] = y0_im;
    w_nre[t1] = x1_re;  w_nim[t1] = x1_im;
    w_nre[u1] = y1_re;  w_nim[u1] = y1_im;
  end

  // Sample capture into the buffer currently being filled.
  always_ff @(posedge clk) begin
    if (fir_valid) smp_mem[sel][scnt] <= fir_d;
  end

  // Frame bookkeeping plus the IDLE/LOAD/STAGE/OUT engine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      scnt      <= '0;
      sel       <= 1'b0;
      pending   <= 1'b0;
      overrun   <= 1'b0;
      fft_valid <= 1'b0;
      for (int i = 0; i < N; i++) begin
        fft_q[i] <= '0;
        w_re[i]  <= '0;
        w_im[i]  <= '0;
      end
    end else begin
      if (fir_valid) scnt <= scnt + 4'd1;

      // A dropped frame keeps sel, so the next frame reuses its buffer and
      // the pending one stays intact. LOAD frees the slot in the same edge.
      if (frame_done) begin
        if (pending && state != LOAD) begin
          overrun <= 1'b1;
        end else begin
          pending <= 1'b1;
          sel     <= ~sel;
        end
      end else if (state == LOAD) begin
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pending) state <= LOAD;
        end
        LOAD: begin
          for (int i = 0; i < N; i++) begin
            w_re[i] <= ACC_W'($signed(smp_mem[~sel][bitrev4(4'(i))]));
            w_im[i] <= '0;
          end
          cnt   <= '0;
          state <= STAGE;
        end
        STAGE: begin
          w_re <= w_nre;
          w_im <= w_nim;
          cnt  <= cnt + 4'd1;
          // Results are latched straight from the final butterflies so the
          // pulse is visible throughout the OUT cycle.
          if (cnt == 4'd15) begin
            for (int i = 0; i < N; i++)
              fft_q[i] <= {sat16(w_nre[i]), sat16(w_nim[i])};
            fft_valid <= 1'b1;
            state     <= OUT;
          end
        end
        default: begin
          fft_valid <= 1'b0;
          state     <= pending ? LOAD : IDLE;
        end
      endcase
    end
  end

  assign fft_d0  = fft_q[0];
  assign fft_d1  = fft_q[1];
  assign fft_d2  = fft_q[2];
  assign fft_d3  = fft_q[3];
  assign fft_d4  = fft_q[4];
  assign fft_d5  = fft_q[5];
  assign fft_d6  = fft_q[6];
  assign fft_d7  = fft_q[7];
  assign fft_d8  = fft_q[8];
  assign fft_d9  = fft_q[9];
  assign fft_d10 = fft_q[10];
  assign fft_d11 = fft_q[11];
  assign fft_d12 = fft_q[12];
  assign fft_d13 = fft_q[13];
  assign fft_d14 = fft_q[14];
  assign fft_d15 = fft_q[15];

endmodule

// File: tb/tb_fft16_iter.sv
// Directed bench for fft16_iter: hand-computed spectra for impulse, DC,
// cosine, saturation and shifted-impulse frames, plus gaps, back-to-back
// frames, reset mid-compute and overrun behaviour.
module tb_fft16_iter;
  import fft16_pkg::*;

  localparam int K_IMP = 0, K_DC = 1, K_COS = 2, K_SAT = 3, K_NSAT = 4, K_ALT = 5;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        fir_valid;
  logic [15:0] fir_d;
  logic [31:0] fft_d [16];
  logic        fft_valid;
  logic        overrun;
  fft_state_t  dbg_state;

  always #5 clk = ~clk;

  fft16_iter dut (
    .clk(clk), .rst(rst), .fir_d(fir_d), .fir_valid(fir_valid),
    .fft_d0(fft_d[0]),   .fft_d1(fft_d[1]),   .fft_d2(fft_d[2]),   .fft_d3(fft_d[3]),
    .fft_d4(fft_d[4]),   .fft_d5(fft_d[5]),   .fft_d6(fft_d[6]),   .fft_d7(fft_d[7]),
    .fft_d8(fft_d[8]),   .fft_d9(fft_d[9]),   .fft_d10(fft_d[10]), .fft_d11(fft_d[11]),
    .fft_d12(fft_d[12]), .fft_d13(fft_d[13]), .fft_d14(fft_d[14]), .fft_d15(fft_d[15]),
    .fft_valid(fft_valid), .overrun(overrun), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          errors = 0;
  int          checks = 0;
  logic [15:0] frame_x  [16];
  logic [31:0] exp_bins [16];
  logic [31:0] exp_q [$];   // expected bins of frames in flight, in order

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Frame contents and their hand-derived spectra.
  task automatic set_case(input int kind);
    for (int i = 0; i < 16; i++) begin
      frame_x[i]  = 16'h0000;
      exp_bins[i] = 32'h0000_0000;
    end
    case (kind)
      K_IMP: begin
        frame_x[0] = 16'h0100;
        for (int k = 0; k < 16; k++) exp_bins[k] = 32'h0100_0000;
      end
      K_DC: begin
        for (int i = 0; i < 16; i++) frame_x[i] = 16'h0100;
        exp_bins[0] = 32'h1000_0000;
      end
      K_COS: begin
        for (int i = 0; i < 16; i++)
          frame_x[i] = (i % 4 == 0) ? 16'h0100 : (i % 4 == 2) ? 16'hFF00 : 16'h0000;
        exp_bins[4]  = 32'h0800_0000;
        exp_bins[12] = 32'h0800_0000;
      end
      K_SAT: begin
        for (int i = 0; i < 16; i++) frame_x[i] = 16'h7FFF;
        exp_bins[0] = 32'h7FFF_0000;
      end
      K_NSAT: begin
        for (int i = 0; i < 16; i++) frame_x[i] = 16'h8000;
        exp_bins[0] = 32'h8000_0000;
      end
      default: begin
        // x[8] = 1.0 gives X[k] = (-1)^k
        frame_x[8] = 16'h0100;
        for (int k = 0; k < 16; k++)
          exp_bins[k] = (k % 2 == 0) ? 32'h0100_0000 : 32'hFF00_0000;
      end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Returns just after the capture edge of the 16th sample.
  task automatic send_frame(input int max_gap);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(negedge clk);
        fir_valid = 1'b0;
      end
      @(negedge clk);
      fir_d     = frame_x[i];
      fir_valid = 1'b1;
    end
    @(posedge clk);
    #1 fir_valid = 1'b0;
  endtask

  // Counts edges until fft_valid is seen (sampled 1ns after each edge).
  task automatic wait_pulse(input string tag, input int budget, output int lat);
    lat = 0;
    while (lat < budget && !fft_valid) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!fft_valid) check({tag, "_timeout"}, 32'(fft_valid), 32'd1);
  endtask

  task automatic check_bins(input string tag);
    for (int k = 0; k < 16; k++)
      check($sformatf("%s_bin%0d", tag, k), fft_d[k], exp_bins[k]);
  endtask

  task automatic run_case(input int kind, input string tag, input int max_gap);
    int lat;
    set_case(kind);
    send_frame(max_gap);
    wait_pulse(tag, 40, lat);
    check({tag, "_latency"}, 32'(lat), 32'd18);
    check_bins(tag);
    @(posedge clk);
    #1 check({tag, "_pulse_end"}, 32'(fft_valid), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int n;
    logic [15:0] b2b_x [48];

    rst = 1'b1;
    fir_valid = 1'b1;   // must be ignored while in reset
    fir_d = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(fft_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    set_case(K_ALT);
    for (int k = 0; k < 16; k++) exp_bins[k] = 32'h0;
    check_bins("rst");
    fir_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_case(K_IMP,  "impulse", 0);
    run_case(K_DC,   "dc", 0);
    run_case(K_COS,  "cos4", 0);
    run_case(K_SAT,  "sat_pos", 0);
    run_case(K_NSAT, "sat_neg", 0);
    run_case(K_ALT,  "imp8", 0);
    run_case(K_DC,   "dc_gaps", 3);

    // outputs hold between pulses
    repeat (10) @(posedge clk);
    #1;
    check("hold_bin0", fft_d[0], 32'h1000_0000);
    check("hold_bin1", fft_d[1], 32'h0);

    // back-to-back: impulse, DC, cosine with no idle cycle between them
    set_case(K_IMP); for (int i = 0; i < 16; i++) begin b2b_x[i]    = frame_x[i]; exp_q.push_back(exp_bins[i]); end
    set_case(K_DC);  for (int i = 0; i < 16; i++) begin b2b_x[16+i] = frame_x[i]; exp_q.push_back(exp_bins[i]); end
    set_case(K_COS); for (int i = 0; i < 16; i++) begin b2b_x[32+i] = frame_x[i]; exp_q.push_back(exp_bins[i]); end
    fork
      begin
        for (int i = 0; i < 48; i++) begin
          @(negedge clk);
          fir_d     = b2b_x[i];
          fir_valid = 1'b1;
        end
        @(negedge clk);
        fir_valid = 1'b0;
      end
      begin
        for (int f = 0; f < 3; f++) begin
          wait_pulse($sformatf("b2b%0d", f), 60, lat);
          for (int k = 0; k < 16; k++)
            check($sformatf("b2b%0d_bin%0d", f, k), fft_d[k], exp_q.pop_front());
          @(posedge clk);
          #1;
        end
      end
    join
    check("b2b_overrun", 32'(overrun), 32'd0);

    // reset during STAGE discards the frame
    set_case(K_DC);
    send_frame(0);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(fft_valid), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    for (int k = 0; k < 16; k++) exp_bins[k] = 32'h0;
    check_bins("midrst");
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (30) begin
      @(posedge clk);
      #1 if (fft_valid) n++;
    end
    check("midrst_no_pulse", 32'(n), 32'd0);
    run_case(K_IMP, "after_rst", 0);

    // overrun: continuous stream, the engine falls 2 cycles behind per frame.
    // Frame 9 completes on the LOAD edge of frame 8 (kept, no overrun);
    // frame 10 completes while frame 9 is still pending (dropped).
    pulse_reset();
    for (int s = 1; s <= 160; s++) begin
      @(negedge clk);
      if (s == 160) check("ovr_before", 32'(overrun), 32'd0);
      fir_d     = 16'(s);
      fir_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    check("ovr_set", 32'(overrun), 32'd1);
    fir_valid = 1'b0;
    repeat (60) @(posedge clk);
    #1 check("ovr_sticky", 32'(overrun), 32'd1);
    pulse_reset();
    #1 check("ovr_cleared", 32'(overrun), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
